// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-client memory arbiter.
package mem_arbiter_pkg;

  localparam int          STARVE_LIMIT_DEF = 4;
  localparam int          TIMEOUT_DEF      = 64;
  localparam logic [31:0] ERR_DATA_DEF     = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_IF,
    ARB_BUSY_LSU
  } mem_arb_state_e;

  // Also used as the bit index into the grant vector.
  typedef enum logic {
    REQ_IF,
    REQ_LSU
  } mem_requestor_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection between fetch and load/store, with a starvation counter
// that lets a long-denied fetch override data priority.
module mem_arb_priority
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mem_en,
  input  logic       if_req,
  input  logic       lsu_req,
  input  logic       idle,
  output logic [1:0] gnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          can_grant;
  logic          starved;

  // Combinational, mutually exclusive grants; fetch wins when data is absent or fetch is starved.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt          = '0;
    // NOTE: grants are gated by reset so a requester never sees an acceptance that reset discards.
    can_grant    = idle & mem_en & ~reset;
    starved      = (starve_cnt == SW'(STARVE_LIMIT));
    gnt[REQ_IF]  = can_grant & if_req & (~lsu_req | starved);
    gnt[REQ_LSU] = can_grant & lsu_req & ~gnt[REQ_IF];
  end

  // Count grant opportunities a pending fetch lost, saturating at the limit.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      starve_cnt <= '0;
    end else if (gnt[REQ_IF]) begin
      starve_cnt <= '0;
    end else if (idle && mem_en && if_req && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store clients onto one single-ported memory,
// holds the request until ack (or timeout) and routes the response back.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int          TIMEOUT      = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA     = ERR_DATA_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        if_req_ip,
  input  logic [31:0] if_addr_ip,
  output logic        if_gnt_op,
  output logic        if_rvalid_op,
  output logic [31:0] if_rdata_op,
  input  logic        lsu_req_ip,
  input  logic        lsu_we_ip,
  input  logic [3:0]  lsu_be_ip,
  input  logic [31:0] lsu_addr_ip,
  input  logic [31:0] lsu_wdata_ip,
  output logic        lsu_gnt_op,
  output logic        lsu_rvalid_op,
  output logic [31:0] lsu_rdata_op,
  output logic        mem_req_op,
  output logic        mem_we_op,
  output logic [3:0]  mem_be_op,
  output logic [31:0] mem_addr_op,
  output logic [31:0] mem_wdata_op,
  input  logic        mem_ack_ip,
  input  logic [31:0] mem_rdata_ip,
  output logic        err_op
);

  localparam int TW = $clog2(TIMEOUT + 1);

  mem_arb_state_e state, state_nxt;
  logic [1:0]     gnt;
  logic [TW-1:0]  tmo_cnt;
  logic           idle;
  logic           busy;
  logic           tmo_hit;
  logic           done;

  assign idle       = (state == ARB_IDLE);
  assign if_gnt_op  = gnt[REQ_IF];
  assign lsu_gnt_op = gnt[REQ_LSU];
  assign mem_req_op = busy;

  mem_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clock  (clock),
    .reset  (reset),
    .mem_en (mem_en),
    .if_req (if_req_ip),
    .lsu_req(lsu_req_ip),
    .idle   (idle),
    .gnt    (gnt)
  );

  // Next-state logic: grant moves to the owner's busy state, ack or timeout returns to idle.
  always_comb begin
    state_nxt = state;
    busy      = (state != ARB_IDLE);
    tmo_hit   = busy && !mem_ack_ip && (tmo_cnt == TW'(TIMEOUT - 1));
    done      = busy && (mem_ack_ip || tmo_hit);
    unique case (state)
      ARB_IDLE: begin
        if (gnt[REQ_IF]) begin
          state_nxt = ARB_BUSY_IF;
        end else if (gnt[REQ_LSU]) begin
          state_nxt = ARB_BUSY_LSU;
        end
      end
      default: begin
        if (done) begin
          state_nxt = ARB_IDLE;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory-side request latch, busy timer and response routing.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we_op     <= 1'b0;
      mem_be_op     <= '0;
      mem_addr_op   <= '0;
      mem_wdata_op  <= '0;
      tmo_cnt       <= '0;
      if_rvalid_op  <= 1'b0;
      if_rdata_op   <= '0;
      lsu_rvalid_op <= 1'b0;
      lsu_rdata_op  <= '0;
      err_op        <= 1'b0;
    end else begin
      if_rvalid_op  <= 1'b0;
      lsu_rvalid_op <= 1'b0;

      if (gnt[REQ_IF]) begin
        mem_we_op    <= 1'b0;
        mem_be_op    <= 4'hF;
        mem_addr_op  <= word_align(if_addr_ip);
        mem_wdata_op <= '0;
      end else if (gnt[REQ_LSU]) begin
        mem_we_op    <= lsu_we_ip;
        mem_be_op    <= lsu_be_ip;
        mem_addr_op  <= word_align(lsu_addr_ip);
        mem_wdata_op <= lsu_wdata_ip;
      end

      // Idle keeps the timer at zero, so it starts from zero on every busy entry.
      tmo_cnt <= busy ? tmo_cnt + TW'(1) : '0;

      if (done) begin
        if (state == ARB_BUSY_IF) begin
          if_rvalid_op <= 1'b1;
          if_rdata_op  <= tmo_hit ? ERR_DATA : mem_rdata_ip;
        end else begin
          lsu_rvalid_op <= 1'b1;
          lsu_rdata_op  <= tmo_hit ? ERR_DATA : (mem_we_op ? '0 : mem_rdata_ip);
        end
        if (tmo_hit) begin
          err_op <= 1'b1;
        end
      end
    end
  end

endmodule
